// File: rtl/sudoku_solution_checker.sv
// Purpose: holds the 81-cell board and scans rows/cols/boxes after each write; flags a complete valid solution.
// Latency: 243 scan cycles after the last accepted write; game_finish rises on the following cycle.
// Backpressure: none; writes arriving mid-scan restart it, writes are ignored once solved.
module sudoku_solution_checker #(
  parameter logic [1:0] SGAME = 2'd1,
  localparam int        CELLS = 81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_init,
  input  logic [1:0] State,
  input  logic       wr_en,
  input  logic [6:0] wr_idx,
  input  logic [3:0] wr_digit,
  input  logic [6:0] rd_idx,
  output logic [3:0] rd_digit,
  output logic       game_finish,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  g, g_nxt;        // group: 0..8 rows, 9..17 columns, 18..26 boxes
  logic [3:0]  k, k_nxt;        // member within group, 0..8
  logic [9:0]  mask, mask_nxt;  // digits already seen in the current group
  logic [3:0]  board [CELLS];

  logic        wr_accept;
  logic [6:0]  g7, k7, b7, row, col, cell_idx;
  logic [3:0]  cur_digit;
  logic [9:0]  digit_bit;
  logic        chk_fail;

  assign wr_accept = wr_en && !game_init && (State == SGAME) && (state != DONE)
                     && (wr_idx <= 7'd80) && (wr_digit <= 4'd9);

  // Map (group, member) to a board cell and test it against the seen-digit mask
  always_comb begin
    g7 = {2'b00, g};
    k7 = {3'b000, k};
    b7 = '0;
    if (g < 5'd9) begin
      row = g7;
      col = k7;
    end else if (g < 5'd18) begin
      row = k7;
      col = g7 - 7'd9;
    end else begin
      b7  = g7 - 7'd18;
      row = (b7 / 7'd3) * 7'd3 + k7 / 7'd3;
      col = (b7 % 7'd3) * 7'd3 + k7 % 7'd3;
    end
    cell_idx  = row * 7'd9 + col;
    cur_digit = board[cell_idx];
    digit_bit = 10'd1 << cur_digit;
    chk_fail  = (cur_digit == 4'd0) || ((mask & digit_bit) != 10'd0);
  end

  // Board storage: cleared by reset/game_init, otherwise updated by accepted writes
  always_ff @(posedge clk) begin
    if (reset || game_init) begin
      for (int i = 0; i < CELLS; i++) board[i] <= 4'd0;
    end else if (wr_accept) begin
      board[wr_idx] <= wr_digit;
    end
  end

  // Display read port; out-of-range indices read as empty
  always_comb begin
    rd_digit = 4'd0;
    if (rd_idx <= 7'd80) rd_digit = board[rd_idx];
  end

  // State, scan counters and registered status outputs
  always_ff @(posedge clk) begin
    if (reset || game_init) begin
      state       <= IDLE;
      g           <= '0;
      k           <= '0;
      mask        <= '0;
      busy        <= 1'b0;
      game_finish <= 1'b0;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      k           <= k_nxt;
      mask        <= mask_nxt;
      busy        <= (state_nxt == SCAN);
      game_finish <= (state_nxt == DONE);
    end
  end

  // Next-state: scan one cell per cycle; an accepted write always restarts the scan
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    k_nxt     = k;
    mask_nxt  = mask;
    if (wr_accept) begin
      state_nxt = SCAN;
      g_nxt     = '0;
      k_nxt     = '0;
      mask_nxt  = '0;
    end else if (state == SCAN) begin
      if (chk_fail) begin
        state_nxt = IDLE;
        g_nxt     = '0;
        k_nxt     = '0;
        mask_nxt  = '0;
      end else if (k == 4'd8) begin
        mask_nxt = '0;
        k_nxt    = '0;
        if (g == 5'd26) begin
          state_nxt = DONE;
          g_nxt     = '0;
        end else begin
          g_nxt = g + 5'd1;
        end
      end else begin
        mask_nxt = mask | digit_bit;
        k_nxt    = k + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_solution_checker.sv
// Purpose: self-checking bench for sudoku_solution_checker using an expected-value queue.
// Latency: checks scan length, finish cycle and hold behaviour against reference values.
// Backpressure: not applicable; stimulus is driven on falling edges, outputs sampled there too.
module tb_sudoku_solution_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_init;
  logic [1:0] State;
  logic       wr_en;
  logic [6:0] wr_idx;
  logic [3:0] wr_digit;
  logic [6:0] rd_idx;
  logic [3:0] rd_digit;
  logic       game_finish;
  logic       busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  sudoku_solution_checker dut (
    .clk         (clk),
    .reset       (reset),
    .game_init   (game_init),
    .State       (State),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_digit    (wr_digit),
    .rd_idx      (rd_idx),
    .rd_digit    (rd_digit),
    .game_finish (game_finish),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d, required finish earlier)", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected value and compare it with what the DUT produced
  task automatic pop_chk(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  function automatic int sol_digit(input int idx);
    int r, c;
    r = idx / 9;
    c = idx % 9;
    return ((3 * r + r / 3 + c) % 9) + 1;
  endfunction

  function automatic int latin_digit(input int idx);
    return ((idx / 9 + idx % 9) % 9) + 1;
  endfunction

  // Drive one write at a falling edge; t is the cycle number of the accepting edge
  task automatic drive_write(input int idx, input int dig, output int t);
    wr_en    = 1'b1;
    wr_idx   = idx[6:0];
    wr_digit = dig[3:0];
    t        = cyc;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_init();
    game_init = 1'b1;
    @(negedge clk);
    game_init = 1'b0;
  endtask

  // Observe a scan until finish or budget; report busy count, first busy cycle, finish cycle
  task automatic watch_scan(input int budget, output int busy_cnt, output int first_busy,
                            output int fin_cyc);
    busy_cnt   = 0;
    first_busy = -1;
    fin_cyc    = -1;
    for (int i = 0; i < budget; i++) begin
      if (game_finish) begin
        fin_cyc = cyc;
        break;
      end
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      @(negedge clk);
    end
  endtask

  // kind: 0 = empty, 1 = valid solution, 2 = latin square
  task automatic check_board(input string tag, input int kind);
    for (int i = 0; i < 81; i++) begin
      rd_idx = i[6:0];
      exp_q.push_back(kind == 0 ? 0 : (kind == 1 ? sol_digit(i) : latin_digit(i)));
      #1;
      pop_chk(tag, int'(rd_digit));
    end
  endtask

  initial begin
    int t, t2, bc, fb, fc, hold_bad, d;
    reset = 1'b1; game_init = 1'b0; State = 2'd1;
    wr_en = 1'b0; wr_idx = '0; wr_digit = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_finish", int'(game_finish), 0);
    chk("rst_busy", int'(busy), 0);
    check_board("rst_board", 0);

    // Valid solution written one cell per cycle
    for (int i = 0; i < 81; i++) drive_write(i, sol_digit(i), t);
    exp_q.push_back(t + 1);
    exp_q.push_back(243);
    exp_q.push_back(t + 244);
    watch_scan(400, bc, fb, fc);
    pop_chk("sol_first_busy", fb);
    pop_chk("sol_busy_cycles", bc);
    pop_chk("sol_finish_cycle", fc);
    hold_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!game_finish || busy) hold_bad++;
      @(negedge clk);
    end
    chk("sol_hold_1000", hold_bad, 0);
    check_board("sol_board", 1);

    // Writes after DONE are rejected
    drive_write(0, 5, t);
    rd_idx = 7'd0;
    #1;
    chk("done_wr_rd0", int'(rd_digit), sol_digit(0));
    chk("done_wr_finish", int'(game_finish), 1);
    chk("done_wr_busy", int'(busy), 0);

    // game_init clears everything
    pulse_init();
    chk("init_finish", int'(game_finish), 0);
    chk("init_busy", int'(busy), 0);
    check_board("init_board", 0);

    // Latin square: rows/cols pass, box 0 fails on its 4th cell
    for (int i = 0; i < 81; i++) drive_write(i, latin_digit(i), t);
    exp_q.push_back(166);
    exp_q.push_back(-1);
    watch_scan(400, bc, fb, fc);
    pop_chk("latin_busy_cycles", bc);
    pop_chk("latin_no_finish", fc);
    chk("latin_busy_end", int'(busy), 0);
    check_board("latin_board", 2);

    // Valid board with centre cell erased: row 4 fails on its 5th cell
    pulse_init();
    for (int i = 0; i < 81; i++) drive_write(i, sol_digit(i), t);
    drive_write(40, 0, t);
    exp_q.push_back(41);
    exp_q.push_back(-1);
    watch_scan(99, bc, fb, fc);
    pop_chk("erase_busy_cycles", bc);
    pop_chk("erase_no_finish", fc);
    while (cyc < t + 100) @(negedge clk);
    drive_write(40, sol_digit(40), t);
    repeat (99) @(negedge clk);
    chk("mid_scan_busy", int'(busy), 1);
    drive_write(40, sol_digit(40), t2);
    exp_q.push_back(243);
    exp_q.push_back(t2 + 244);
    watch_scan(400, bc, fb, fc);
    pop_chk("restart_busy_cycles", bc);
    pop_chk("restart_finish_cycle", fc);

    // Rejected writes: wrong State, bad index, bad digit
    pulse_init();
    for (int v = 0; v < 4; v++) begin
      State = (v == 0) ? 2'd0 : (v == 1) ? 2'd2 : 2'd1;
      d = (v == 3) ? 10 : 7;
      drive_write((v == 2) ? 81 : 0, d, t);
      State = 2'd1;
      @(negedge clk);
      rd_idx = 7'd0;
      #1;
      chk($sformatf("rej%0d_rd0", v), int'(rd_digit), 0);
      chk($sformatf("rej%0d_busy", v), int'(busy), 0);
    end
    rd_idx = 7'd81;
    #1;
    chk("rd_oob", int'(rd_digit), 0);
    check_board("rej_board", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
